// File: rtl/fft_peak_detect.sv
// FFT bin power stage: streams re^2+im^2 and reports the per-frame peak bin.
// Define PEAK_DETECT_DC_SKIP_EN to exclude bin 0 from the peak search.
module fft_peak_detect #(
    parameter int DATA_WIDTH = 32,
    parameter int NFFT_LOG2  = 13
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  peak_valid,
    output logic [NFFT_LOG2-1:0]  peak_index,
    output logic [DATA_WIDTH-1:0] peak_power,
    output logic [15:0]           frame_count,
    output logic                  err_tlast_early,
    output logic                  err_tlast_missing
);

    localparam int W = DATA_WIDTH;
    localparam int H = DATA_WIDTH / 2;
    localparam logic [NFFT_LOG2-1:0] BIN_MAX = '1;

    typedef enum logic {
        ST_FIRST,
        ST_ACCUM
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                 r_rdy_en;
    logic                 w_advance;
    logic                 w_accept;
    logic                 w_hs;
    logic                 w_bin_max;
    logic                 w_frame_end;
    logic                 w_peak_done;
    logic [NFFT_LOG2-1:0] r_bin;

    logic signed [H-1:0] w_re;
    logic signed [H-1:0] w_im;
    logic signed [W-2:0] w_re_x;
    logic signed [W-2:0] w_im_x;
    logic signed [W-2:0] w_re_sq;
    logic signed [W-2:0] w_im_sq;

    logic                 r_s1_valid;
    logic                 r_s1_last;
    logic                 r_s1_end;
    logic [W-2:0]         r_s1_re2;
    logic [W-2:0]         r_s1_im2;
    logic [NFFT_LOG2-1:0] r_s1_idx;
    logic                 r_s2_end;
    logic [NFFT_LOG2-1:0] r_s2_idx;

    logic [W-1:0]         r_max;
    logic [NFFT_LOG2-1:0] r_max_idx;
    logic [W-1:0]         w_max_nxt;
    logic [NFFT_LOG2-1:0] w_idx_nxt;

    assign w_advance     = m_axis_tready | ~m_axis_tvalid;
    assign s_axis_tready = r_rdy_en & w_advance;
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_hs          = m_axis_tvalid & m_axis_tready;
    assign w_bin_max     = (r_bin == BIN_MAX);
    assign w_frame_end   = s_axis_tlast | w_bin_max;
    assign w_peak_done   = w_hs & r_s2_end;

    // Squares of H-bit signed values fit in W-1 bits when read unsigned.
    assign w_re    = s_axis_tdata[H-1:0];
    assign w_im    = s_axis_tdata[W-1:H];
    assign w_re_x  = {{(H-1){w_re[H-1]}}, w_re};
    assign w_im_x  = {{(H-1){w_im[H-1]}}, w_im};
    assign w_re_sq = w_re_x * w_re_x;
    assign w_im_sq = w_im_x * w_im_x;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_bin             <= '0;
            err_tlast_early   <= 1'b0;
            err_tlast_missing <= 1'b0;
        end else begin
            err_tlast_early   <= w_accept & s_axis_tlast & ~w_bin_max;
            err_tlast_missing <= w_accept & w_bin_max & ~s_axis_tlast;
            if (w_accept) begin
                r_bin <= w_frame_end ? '0 : r_bin + NFFT_LOG2'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_s1_valid    <= 1'b0;
            r_s1_last     <= 1'b0;
            r_s1_end      <= 1'b0;
            r_s1_re2      <= '0;
            r_s1_im2      <= '0;
            r_s1_idx      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            r_s2_end      <= 1'b0;
            r_s2_idx      <= '0;
        end else if (w_advance) begin
            r_s1_valid    <= w_accept;
            m_axis_tvalid <= r_s1_valid;
            if (w_accept) begin
                r_s1_re2  <= w_re_sq;
                r_s1_im2  <= w_im_sq;
                r_s1_last <= s_axis_tlast;
                r_s1_end  <= w_frame_end;
                r_s1_idx  <= r_bin;
            end
            if (r_s1_valid) begin
                m_axis_tdata <= {1'b0, r_s1_re2} + {1'b0, r_s1_im2};
                m_axis_tlast <= r_s1_last;
                r_s2_end     <= r_s1_end;
                r_s2_idx     <= r_s1_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_max_nxt   = r_max;
        w_idx_nxt   = r_max_idx;
        if (w_hs) begin
            unique case (r_state)
                ST_FIRST: begin
                    w_max_nxt = m_axis_tdata;
                    w_idx_nxt = r_s2_idx;
`ifdef PEAK_DETECT_DC_SKIP_EN
                    if (r_s2_idx == '0) begin
                        w_max_nxt = '0;
                        w_idx_nxt = '0;
                    end
`endif
                    w_state_nxt = r_s2_end ? ST_FIRST : ST_ACCUM;
                end
                ST_ACCUM: begin
                    // Strict compare so ties keep the earliest bin.
                    if (m_axis_tdata > r_max) begin
                        w_max_nxt = m_axis_tdata;
                        w_idx_nxt = r_s2_idx;
                    end
                    w_state_nxt = r_s2_end ? ST_FIRST : ST_ACCUM;
                end
                default: w_state_nxt = ST_FIRST;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_FIRST;
            r_max       <= '0;
            r_max_idx   <= '0;
            peak_valid  <= 1'b0;
            peak_index  <= '0;
            peak_power  <= '0;
            frame_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            peak_valid <= w_peak_done;
            if (w_hs) begin
                r_max     <= w_max_nxt;
                r_max_idx <= w_idx_nxt;
            end
            if (w_peak_done) begin
                peak_index  <= w_idx_nxt;
                peak_power  <= w_max_nxt;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect with 16-bin frames.
module tb_fft_peak_detect;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        peak_valid;
    logic [3:0]  peak_index;
    logic [31:0] peak_power;
    logic [15:0] frame_count;
    logic        err_tlast_early;
    logic        err_tlast_missing;

    fft_peak_detect #(
        .DATA_WIDTH(32),
        .NFFT_LOG2(4)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .peak_valid(peak_valid),
        .peak_index(peak_index),
        .peak_power(peak_power),
        .frame_count(frame_count),
        .err_tlast_early(err_tlast_early),
        .err_tlast_missing(err_tlast_missing)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [3:0]  bin;
        logic [31:0] pow;
    } vec_t;

    beat_t in_q[$];
    beat_t exp_q[$];
    int total = 0;
    int bad = 0;
    int pk_cnt = 0;
    int early_cnt = 0;
    int miss_cnt = 0;
    int fc_exp = 0;
    logic [3:0]  pk_idx = '0;
    logic [31:0] pk_pow = '0;
    logic        rdy_rand = 1'b0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_val = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pw(input logic [15:0] re, input logic [15:0] im);
        logic signed [15:0] rs;
        logic signed [15:0] is;
        longint a;
        longint b;
        rs = re;
        is = im;
        a = rs;
        b = is;
        return 32'(a * a + b * b);
    endfunction

    task automatic add_beat(input logic [15:0] re, input logic [15:0] im,
                            input logic last);
        in_q.push_back({{im, re}, last});
        exp_q.push_back({pw(re, im), last});
    endtask

    task automatic tick();
        beat_t b;
        logic hs_o;
        logic acc_i;
        @(negedge aclk);
        m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (in_q.size() > 0) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = in_q[0].data;
            s_axis_tlast  = in_q[0].last;
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = '0;
            s_axis_tlast  = 1'b0;
        end
        #1;
        if (peak_valid) begin
            pk_cnt++;
            pk_idx = peak_index;
            pk_pow = peak_power;
        end
        if (err_tlast_early) early_cnt++;
        if (err_tlast_missing) miss_cnt++;
        if (prev_stall) check("stall_hold", {m_axis_tdata, m_axis_tlast}, prev_val);
        if (m_axis_tvalid && !m_axis_tready) begin
            check("stall_rdy", s_axis_tready, 0);
            prev_stall = 1'b1;
            prev_val = {m_axis_tdata, m_axis_tlast};
        end else begin
            prev_stall = 1'b0;
        end
        hs_o  = m_axis_tvalid & m_axis_tready;
        acc_i = s_axis_tvalid & s_axis_tready;
        if (hs_o) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                b = exp_q.pop_front();
                check("power", m_axis_tdata, b.data);
                check("tlast", m_axis_tlast, b.last);
            end
        end
        if (acc_i) void'(in_q.pop_front());
        @(posedge aclk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < 500) begin
            tick();
            n++;
        end
        if (in_q.size() > 0 || exp_q.size() > 0) check("drain_timeout", 1, 0);
        repeat (3) tick();
    endtask

    task automatic frame_one(input logic [3:0] bin, input logic [15:0] re,
                             input logic [15:0] im);
        for (int b = 0; b < 16; b++) begin
            if (4'(b) == bin) add_beat(re, im, b == 15);
            else add_beat(16'h0, 16'h0, b == 15);
        end
    endtask

    task automatic check_peak(input string nm, input logic [3:0] idx,
                              input logic [31:0] pwr);
        fc_exp++;
        check({nm, "_idx"}, pk_idx, idx);
        check({nm, "_pow"}, pk_pow, pwr);
        check({nm, "_pcnt"}, pk_cnt, fc_exp);
        check({nm, "_fcnt"}, frame_count, fc_exp);
    endtask

    vec_t tbl[5];
    int pk_before;

    initial begin
        tbl[0] = '{re: 16'h7FFF, im: 16'h0000, bin: 4'd5,  pow: 32'h3FFF0001};
        tbl[1] = '{re: 16'h8000, im: 16'h8000, bin: 4'd3,  pow: 32'h80000000};
        tbl[2] = '{re: 16'h0003, im: 16'hFFFC, bin: 4'd14, pow: 32'd25};
        tbl[3] = '{re: 16'h0000, im: 16'h8001, bin: 4'd15, pow: 32'h3FFF0001};
        tbl[4] = '{re: 16'h0001, im: 16'h0001, bin: 4'd1,  pow: 32'd2};

        aresetn = 1'b0;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        check("rst_stream", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready}, 0);
        check("rst_peak", {peak_valid, peak_index, peak_power, frame_count,
                           err_tlast_early, err_tlast_missing}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        check("rdy_after_rst", s_axis_tready, 1);

        for (int i = 0; i < 5; i++) begin
            frame_one(tbl[i].bin, tbl[i].re, tbl[i].im);
            drain();
            check_peak("tbl", tbl[i].bin, tbl[i].pow);
        end

        rdy_rand = 1'b1;
        for (int b = 0; b < 16; b++) begin
            if (b == 2 || b == 9) add_beat(16'd10, 16'd0, b == 15);
            else add_beat(16'(b % 4), 16'd0, b == 15);
        end
        drain();
        rdy_rand = 1'b0;
        check_peak("tie", 4'd2, 32'd100);

        for (int b = 0; b < 8; b++) add_beat(b == 6 ? 16'd20 : 16'd1, 16'd0, b == 7);
        drain();
        check("early_err", early_cnt, 1);
        check("early_nomiss", miss_cnt, 0);
        check_peak("early", 4'd6, 32'd400);
        frame_one(4'd1, 16'd5, 16'd0);
        drain();
        check_peak("restart", 4'd1, 32'd25);
        check("restart_early", early_cnt, 1);

        for (int b = 0; b < 16; b++) add_beat(b == 12 ? 16'd7 : 16'd0, 16'd0, 1'b0);
        drain();
        check("miss_err", miss_cnt, 1);
        check_peak("miss", 4'd12, 32'd49);
        frame_one(4'd3, 16'd2, 16'd0);
        drain();
        check_peak("after_miss", 4'd3, 32'd4);
        check("after_miss_err", miss_cnt + early_cnt, 2);

        for (int b = 0; b < 16; b++) begin
            if (b == 0) add_beat(16'd30, 16'd10, 1'b0);
            else if (b == 4) add_beat(16'd3, 16'd1, 1'b0);
            else add_beat(16'd0, 16'd0, b == 15);
        end
        drain();
`ifdef PEAK_DETECT_DC_SKIP_EN
        check_peak("dc", 4'd4, 32'd10);
`else
        check_peak("dc", 4'd0, 32'd1000);
`endif

        frame_one(4'd9, 16'd9, 16'd0);
        repeat (6) tick();
        pk_before = pk_cnt;
        @(negedge aclk);
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check("midrst_stream", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready}, 0);
        check("midrst_peak", {peak_valid, peak_index, peak_power, frame_count,
                              err_tlast_early, err_tlast_missing}, 0);
        in_q.delete();
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (4) tick();
        check("midrst_nopeak", pk_cnt, pk_before);
        check("midrst_errs", early_cnt + miss_cnt, 2);
        fc_exp = 0;
        pk_cnt = 0;
        frame_one(4'd5, 16'h7FFF, 16'h0);
        drain();
        check_peak("post_rst", 4'd5, 32'h3FFF0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_peak_detect.md
# fft_peak_detect

Downstream stage of the FFT core in the GPR receive chain. It consumes the complex FFT output stream (real in the low half, imaginary in the high half), converts each bin to power (re² + im²), and forwards the power stream with frame framing preserved. Per frame, it also reports the strongest bin and its index, which the range-gating logic uses.

## Interface
Parameters:
- DATA_WIDTH, 32, input sample width; low half = signed real, high half = signed imag; output power width equals DATA_WIDTH.
- NFFT_LOG2, 13, log2 of frame length (8192 bins, matching the FFT config).

Ports:
- aclk  in  1  sole clock; all logic is synchronous to its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  FFT bin {im, re}.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tlast  in  1  last bin of frame.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_WIDTH  unsigned power re²+im².
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  last bin of frame; delayed copy of s_axis_tlast.
- m_axis_tready  in  1  downstream ready.
- peak_valid  out  1  one-cycle pulse; the peak outputs below are valid.
- peak_index  out  NFFT_LOG2  bin index of maximum power.
- peak_power  out  DATA_WIDTH  maximum power value.
- frame_count  out  16  completed frames, wraps at 65535→0.
- err_tlast_early  out  1  pulse: tlast arrived before bin 2^NFFT_LOG2-1.
- err_tlast_missing  out  1  pulse: bin 2^NFFT_LOG2-1 accepted without tlast.

## Operation
- Two-stage pipeline:
  - S1 registers signed re², im² (each DATA_WIDTH-1 bits signed product, treated unsigned).
  - S2 registers the sum into m_axis_tdata.
  - Max value is 2·(−2^(W/2−1))² = 2^(W−1), which fits in DATA_WIDTH unsigned with no saturation.
- tlast and bin index travel with data through both stages.
- Global stall pipeline: advance = m_axis_tready | ~m_axis_tvalid. A bubble in S1 is filled when the S1 slot is empty. Internal valids are held per stage.
- s_axis_tready = advance. The input is accepted on s_axis_tvalid & s_axis_tready.
- Bin counter: increments per accepted input beat and clears on frame end. Frame end is the accepted beat with tlast, or the beat at index 2^NFFT_LOG2-1.
- Error flags, evaluated at the accepted input beat:
  - tlast at index < max raises err_tlast_early.
  - Index == max without tlast raises err_tlast_missing.
  - Either condition ends the frame.
- Peak FSM, evaluated on output handshakes (m_axis_tvalid & m_axis_tready):
  - ST_FIRST: the beat loads running max and index unconditionally. Go to ST_ACCUM, or stay in ST_FIRST if the beat is also the frame end.
  - ST_ACCUM: the running max is updated only if power > running max (strict). Ties keep the lowest index.
  - On the frame-end beat, the comparison includes that beat. On the next cycle, peak_index/peak_power are registered, peak_valid pulses, frame_count increments, and the FSM returns to ST_FIRST.
- peak_index/peak_power hold until the next frame result.

## Timing
- Reset values (async assert): all valids 0, m_axis_tdata 0, m_axis_tlast 0, peak_* 0, peak_valid 0, frame_count 0, err_* 0, FSM ST_FIRST, bin counter 0.
- s_axis_tready is 0 during reset. It is 1 one cycle after deassertion, since the output is empty.
- Latency: input accept at cycle N → m_axis_tvalid at N+2 when unstalled. Throughput is 1 beat/cycle.
- peak_valid asserts 1 cycle after the frame-end output handshake.
- Stall: while m_axis_tvalid & ~m_axis_tready, m_axis_tdata and m_axis_tlast hold stable and s_axis_tready = 0.
- Reset mid-frame: partial frame is discarded, no peak_valid, no error pulse.
- Error pulses are asserted 1 cycle after the offending input accept.

## Configuration
- PEAK_DETECT_DC_SKIP_EN defined: bin 0 is excluded from the peak search. In ST_FIRST, bin 0 loads max = 0, index = 0. A frame of all-zero power other than DC reports index 0, power 0.
- Not defined: bin 0 participates like any other bin.
- The power stream is unaffected either way.

## Test plan
Bench uses NFFT_LOG2 = 4 (16-bin frames) unless stated.
- Reset: aresetn low mid-stream → every output is 0 the same cycle. After release, s_axis_tready = 1 next cycle.
- Impulse: frame with bin 5 = {im 0, re 16'h7FFF}, others 0; m_axis_tready = 1 → m_axis_tdata at bin 5 = 32'h3FFF0001, peak_index 5, peak_power 32'h3FFF0001, frame_count 1.
- Extreme negative: re = im = 16'h8000 at bin 3 → power 32'h80000000, peak_index 3.
- Tie plus backpressure: bins 2 and 9 both power 100, m_axis_tready random 50% → peak_index 2. All 16 output beats are in order, with tlast only on the 16th.
- Early tlast: tlast on bin 7 → err_tlast_early pulses, peak reported over bins 0–7, next frame restarts at index 0. Missing tlast: 16 beats without tlast → err_tlast_missing pulses, frame closes.
- With PEAK_DETECT_DC_SKIP_EN: bin 0 power 1000, bin 4 power 10 → peak_index 4. Without the macro → peak_index 0.
